ram_sync_param: RTL and testbench

- Parametrised successor of the team's 16x8 RAM, with width and depth set by parameters.
- Single-port synchronous RAM with a registered read (one-cycle latency) and a read-valid strobe.
- Includes a hardware clear engine that zeroes the whole array after reset or on request.
- Separate data_in/data_out buses replace the tri-state bus, so the block can sit behind the datapath register file and bus bridges.

---
 rtl/ram_pkg.sv | 18 +
 rtl/ram_clr_ctrl.sv | 70 +++++++
 rtl/ram_sync_param.sv | 119 +++++++++++
 tb/tb_ram_sync_param.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the parametrised single-port RAM: defaults,
// clear-engine state encoding and the even-parity helper.
package ram_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } ram_state_e;

    // Words narrower than 64 bits are zero-extended, which leaves parity unchanged
    function automatic logic even_parity(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/ram_clr_ctrl.sv
// Clear engine for ram_sync_param: walks clr_addr over every implemented
// word after reset or on clr_req, holding busy for exactly DEPTH cycles.
module ram_clr_ctrl
    import ram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    ram_state_e        state_r;
    ram_state_e        state_s;
    logic [ADDR_W-1:0] clr_addr_r;
    logic [ADDR_W-1:0] clr_addr_s;
    logic              busy_r;

    // Next-state and clear-address sequencing; clr_req is only honoured in IDLE
    always_comb begin
        state_s    = state_r;
        clr_addr_s = clr_addr_r;
        case (state_r)
            ST_CLEAR: begin
                if (clr_addr_r == LAST_ADDR) begin
                    state_s    = ST_IDLE;
                    clr_addr_s = '0;
                end else begin
                    clr_addr_s = clr_addr_r + ADDR_W'(1'b1);
                end
            end
            ST_IDLE: begin
                if (clr_req) begin
                    state_s    = ST_CLEAR;
                    clr_addr_s = '0;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            default: begin
                state_s    = ST_CLEAR;
                clr_addr_s = '0;
            end
        endcase
    end

    // State, address counter and busy flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_CLEAR;
            clr_addr_r <= '0;
            busy_r     <= 1'b1;
        end else begin
            state_r    <= state_s;
            clr_addr_r <= clr_addr_s;
            busy_r     <= (state_s == ST_CLEAR);
        end
    end

    assign busy     = busy_r;
    assign clr_we   = (state_r == ST_CLEAR);
    assign clr_addr = clr_addr_r;

endmodule

// File: rtl/ram_sync_param.sv
// Single-port synchronous RAM with registered read, read-valid strobe and a
// hardware clear engine. Define RAM_PARITY_EN to add per-word even parity.
module ram_sync_param
    import ram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs,
    input  logic              wa,
    input  logic              oa,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    input  logic              clr_req,
    output logic              busy,
    output logic              par_err
);

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              busy_s;
    logic              clr_we_s;
    logic [ADDR_W-1:0] clr_addr_s;
    logic [IDX_W-1:0]  clr_idx_s;
    logic [IDX_W-1:0]  idx_s;
    logic              in_range_s;
    logic              access_s;
    logic              rd_en_s;
    logic              wr_en_s;
    logic [DATA_W-1:0] data_out_r;
    logic              rd_valid_r;

    ram_clr_ctrl #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_clr_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .busy     (busy_s),
        .clr_we   (clr_we_s),
        .clr_addr (clr_addr_s)
    );

    // Access decode: clr_req wins over any access presented in the same cycle
    always_comb begin
        in_range_s = ({1'b0, addr} < DEPTH_L);
        idx_s      = addr[IDX_W-1:0];
        clr_idx_s  = clr_addr_s[IDX_W-1:0];
        access_s   = ~busy_s & ~clr_req & cs;
        rd_en_s    = access_s & oa;
        wr_en_s    = access_s & wa & ~oa & in_range_s;
    end

    // Array write port shared by the clear engine and host writes
    always_ff @(posedge clk) begin
        if (clr_we_s) begin
            mem[clr_idx_s] <= '0;
        end else if (wr_en_s) begin
            mem[idx_s] <= data_in;
        end
    end

    // Registered read path; data_out is zero on every cycle without a read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_r <= '0;
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_en_s;
            if (rd_en_s && in_range_s) begin
                data_out_r <= mem[idx_s];
            end else begin
                data_out_r <= '0;
            end
        end
    end

`ifdef RAM_PARITY_EN
    logic par_mem [DEPTH];
    logic par_err_r;

    // Parity bit storage, written alongside the data word
    always_ff @(posedge clk) begin
        if (clr_we_s) begin
            par_mem[clr_idx_s] <= 1'b0;
        end else if (wr_en_s) begin
            par_mem[idx_s] <= even_parity(64'(data_in));
        end
    end

    // Parity check of the word being read, aligned with rd_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err_r <= 1'b0;
        end else begin
            par_err_r <= rd_en_s & in_range_s &
                         (even_parity(64'(mem[idx_s])) != par_mem[idx_s]);
        end
    end

    assign par_err = par_err_r;
`else
    assign par_err = 1'b0;
`endif

    assign data_out = data_out_r;
    assign rd_valid = rd_valid_r;
    assign busy     = busy_s;

endmodule

// File: tb/tb_ram_sync_param.sv
// Self-checking bench for ram_sync_param: a full-depth (16) and a partial-depth
// (12) instance share stimulus and are checked against a behavioural model.
module tb_ram_sync_param;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b1;
    logic       cs      = 1'b0;
    logic       wa      = 1'b0;
    logic       oa      = 1'b0;
    logic       clr_req = 1'b0;
    logic [3:0] addr    = 4'd0;
    logic [7:0] data_in = 8'h00;

    logic [7:0] do16, do12;
    logic       rv16, rv12, bz16, bz12, pe16, pe12;

    logic [7:0] dout [2];
    logic       rv   [2];
    logic       bz   [2];
    logic       pe   [2];

    int checks = 0;
    int errors = 0;

    // Reference model: per-instance word contents and remaining clear cycles
    int         dep       [2] = '{16, 12};
    logic [7:0] mdl       [2][16];
    int         busy_left [2] = '{16, 12};
    logic [7:0] exp_d     [2];
    logic       exp_v     [2];

    ram_sync_param #(.DATA_W(8), .ADDR_W(4), .DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .cs(cs), .wa(wa), .oa(oa), .addr(addr),
        .data_in(data_in), .data_out(do16), .rd_valid(rv16), .clr_req(clr_req),
        .busy(bz16), .par_err(pe16)
    );

    ram_sync_param #(.DATA_W(8), .ADDR_W(4), .DEPTH(12)) dut12 (
        .clk(clk), .rst_n(rst_n), .cs(cs), .wa(wa), .oa(oa), .addr(addr),
        .data_in(data_in), .data_out(do12), .rd_valid(rv12), .clr_req(clr_req),
        .busy(bz12), .par_err(pe12)
    );

    always #5 clk = ~clk;

    always_comb begin
        dout[0] = do16; dout[1] = do12;
        rv[0]   = rv16; rv[1]   = rv12;
        bz[0]   = bz16; bz[1]   = bz12;
        pe[0]   = pe16; pe[1]   = pe12;
    end

    task automatic drive(input logic c, input logic w, input logic o,
                         input logic [3:0] a, input logic [7:0] d, input logic cr);
        cs = c; wa = w; oa = o; addr = a; data_in = d; clr_req = cr;
    endtask

    // Apply the model's rules to the inputs present at the coming edge, then cross it
    task automatic step();
        for (int k = 0; k < 2; k++) begin
            exp_d[k] = 8'h00;
            exp_v[k] = 1'b0;
            if (!rst_n) begin
                busy_left[k] = dep[k];
                for (int i = 0; i < 16; i++) mdl[k][i] = 8'h00;
            end else if (busy_left[k] > 0) begin
                busy_left[k]--;
            end else if (clr_req) begin
                busy_left[k] = dep[k];
                for (int i = 0; i < 16; i++) mdl[k][i] = 8'h00;
            end else if (cs && oa) begin
                exp_v[k] = 1'b1;
                if (int'(addr) < dep[k]) exp_d[k] = mdl[k][addr];
            end else if (cs && wa && int'(addr) < dep[k]) begin
                mdl[k][addr] = data_in;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({dout[k], rv[k], bz[k], pe[k]} !== {8'h00, 1'b0, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL reset_state dut%0d got data=%h valid=%0b busy=%0b par=%0b want data=00 valid=0 busy=1 par=0",
                         dep[k], dout[k], rv[k], bz[k], pe[k]);
            end
        end
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (bz[k] !== (i < dep[k] - 1)) begin
                    errors++;
                    $display("FAIL busy_after_reset dut%0d cycle %0d got %0b want %0b",
                             dep[k], i, bz[k], (i < dep[k] - 1));
                end
            end
        end
    endtask

    task automatic test_zero_reads();
        for (int a = 0; a < 16; a++) begin
            drive(1'b1, 1'b0, 1'b1, 4'(a), 8'h00, 1'b0);
            step();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if ({rv[k], dout[k], pe[k]} !== {1'b1, 8'h00, 1'b0}) begin
                    errors++;
                    $display("FAIL zero_read dut%0d addr %0d got valid=%0b data=%h par=%0b want valid=1 data=00 par=0",
                             dep[k], a, rv[k], dout[k], pe[k]);
                end
            end
        end
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
        step();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({rv[k], dout[k]} !== {1'b0, 8'h00}) begin
                errors++;
                $display("FAIL idle_after_reads dut%0d got valid=%0b data=%h want valid=0 data=00",
                         dep[k], rv[k], dout[k]);
            end
        end
    endtask

    task automatic test_write_read();
        logic [8:0] want [2][3];
        want[0] = '{9'h1A5, 9'h15A, 9'h000};
        want[1] = '{9'h1A5, 9'h100, 9'h000};
        drive(1'b1, 1'b1, 1'b0, 4'd3, 8'hA5, 1'b0);  step();
        drive(1'b1, 1'b1, 1'b0, 4'd15, 8'h5A, 1'b0); step();
        for (int n = 0; n < 3; n++) begin
            if (n == 0)      drive(1'b1, 1'b0, 1'b1, 4'd3, 8'h00, 1'b0);
            else if (n == 1) drive(1'b1, 1'b0, 1'b1, 4'd15, 8'h00, 1'b0);
            else             drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
            step();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if ({rv[k], dout[k]} !== want[k][n]) begin
                    errors++;
                    $display("FAIL write_read dut%0d slot %0d got valid=%0b data=%h want %h",
                             dep[k], n, rv[k], dout[k], want[k][n]);
                end
            end
        end
    endtask

    task automatic test_controls();
        drive(1'b0, 1'b1, 1'b0, 4'd3, 8'h11, 1'b0); step();
        drive(1'b1, 1'b1, 1'b1, 4'd3, 8'hFF, 1'b0); step();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({rv[k], dout[k]} !== 9'h1A5) begin
                errors++;
                $display("FAIL cs_wa_oa_read dut%0d got valid=%0b data=%h want valid=1 data=a5",
                         dep[k], rv[k], dout[k]);
            end
        end
        drive(1'b1, 1'b0, 1'b1, 4'd3, 8'h00, 1'b0); step();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({rv[k], dout[k]} !== 9'h1A5) begin
                errors++;
                $display("FAIL no_write_check dut%0d got valid=%0b data=%h want valid=1 data=a5",
                         dep[k], rv[k], dout[k]);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0); step();
    endtask

    task automatic test_clear();
        drive(1'b1, 1'b1, 1'b0, 4'd7, 8'h77, 1'b0); step();
        drive(1'b1, 1'b1, 1'b0, 4'd8, 8'h88, 1'b1); step();
        for (int j = 1; j <= 16; j++) begin
            // Reads during the clear must be ignored; a second clr_req must not restart it
            if (j <= 12) drive(1'b1, 1'b0, 1'b1, 4'd7, 8'h00, (j == 5));
            else         drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
            step();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (bz[k] !== (j < dep[k])) begin
                    errors++;
                    $display("FAIL clear_busy dut%0d cycle %0d got %0b want %0b", dep[k], j, bz[k], (j < dep[k]));
                end
                if (j <= 12) begin
                    checks++;
                    if (rv[k] !== 1'b0) begin
                        errors++;
                        $display("FAIL read_during_clear dut%0d cycle %0d got valid=%0b want 0", dep[k], j, rv[k]);
                    end
                end
            end
        end
        for (int n = 0; n < 2; n++) begin
            drive(1'b1, 1'b0, 1'b1, (n == 0) ? 4'd7 : 4'd8, 8'h00, 1'b0);
            step();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if ({rv[k], dout[k]} !== 9'h100) begin
                    errors++;
                    $display("FAIL cleared_word dut%0d addr %0d got valid=%0b data=%h want valid=1 data=00",
                             dep[k], 7 + n, rv[k], dout[k]);
                end
            end
        end
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0); step();
    endtask

    task automatic test_boundary();
        logic [8:0] want [2][2];
        want[0] = '{9'h133, 9'h100};
        want[1] = '{9'h100, 9'h100};
        drive(1'b1, 1'b1, 1'b0, 4'd13, 8'h33, 1'b0); step();
        for (int n = 0; n < 2; n++) begin
            drive(1'b1, 1'b0, 1'b1, (n == 0) ? 4'd13 : 4'd1, 8'h00, 1'b0);
            step();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if ({rv[k], dout[k]} !== want[k][n]) begin
                    errors++;
                    $display("FAIL out_of_range dut%0d slot %0d got valid=%0b data=%h want %h",
                             dep[k], n, rv[k], dout[k], want[k][n]);
                end
            end
        end
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0); step();
    endtask

    task automatic test_reset_mid_clear();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1); step();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
        for (int j = 0; j < 4; j++) step();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({bz[k], rv[k], dout[k]} !== {1'b1, 1'b0, 8'h00}) begin
                errors++;
                $display("FAIL reset_mid_clear dut%0d got busy=%0b valid=%0b data=%h want busy=1 valid=0 data=00",
                         dep[k], bz[k], rv[k], dout[k]);
            end
        end
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (bz[k] !== (i < dep[k] - 1)) begin
                    errors++;
                    $display("FAIL busy_restart dut%0d cycle %0d got %0b want %0b",
                             dep[k], i, bz[k], (i < dep[k] - 1));
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 4'($urandom),
                  8'($urandom), ($urandom_range(0, 63) == 0));
            step();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if ({rv[k], dout[k], bz[k], pe[k]} !== {exp_v[k], exp_d[k], (busy_left[k] > 0), 1'b0}) begin
                    errors++;
                    $display("FAIL random dut%0d iter %0d got valid=%0b data=%h busy=%0b par=%0b want valid=%0b data=%h busy=%0b par=0",
                             dep[k], n, rv[k], dout[k], bz[k], pe[k], exp_v[k], exp_d[k], (busy_left[k] > 0));
                end
            end
        end
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
    endtask

`ifdef RAM_PARITY_EN
    task automatic test_parity();
        int guard = 0;
        while ((bz16 || bz12) && guard < 20) begin
            step();
            guard++;
        end
        checks++;
        if (bz16 !== 1'b0) begin
            errors++;
            $display("FAIL parity_wait_idle got busy=%0b want 0", bz16);
        end
        drive(1'b1, 1'b1, 1'b0, 4'd5, 8'h3C, 1'b0); step();
        drive(1'b1, 1'b1, 1'b0, 4'd6, 8'h3C, 1'b0); step();
        dut.mem[5][0] = ~dut.mem[5][0];
        drive(1'b1, 1'b0, 1'b1, 4'd5, 8'h00, 1'b0); step();
        checks++;
        if ({rv16, pe16} !== 2'b11) begin
            errors++;
            $display("FAIL parity_flip got valid=%0b par=%0b want valid=1 par=1", rv16, pe16);
        end
        drive(1'b1, 1'b0, 1'b1, 4'd6, 8'h00, 1'b0); step();
        checks++;
        if ({rv16, dout[0], pe16} !== {1'b1, 8'h3C, 1'b0}) begin
            errors++;
            $display("FAIL parity_clean got valid=%0b data=%h par=%0b want valid=1 data=3c par=0", rv16, dout[0], pe16);
        end
        drive(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0); step();
    endtask
`endif

    initial begin
        test_reset();
        test_zero_reads();
        test_write_read();
        test_controls();
        test_clear();
        test_boundary();
        test_reset_mid_clear();
        test_random();
`ifdef RAM_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish got time %0t want under 200000", $time);
        $fatal(1, "timeout");
    end

endmodule
